// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver with a small valid/ready FIFO, sticky overflow flag and
// a debug copy of the last byte written to the FIFO.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          framing_err,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [7:0]                    dbg_last
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic          rx_m, rx_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, ferr;
  logic          expired;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_n;
  logic          pop, full, push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      framing_err <= ferr;
    end
  end

  assign expired = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_LOAD;
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (expired) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            cnt_n   = FULL_LOAD;
            idx_n   = 3'd0;
            state_n = S_DATA;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (expired) begin
          // LSB arrives first, so shifting right leaves bit 0 in place after 8 bits
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = FULL_LOAD;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            state_n = S_DATA;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (expired) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_BREAK: begin
        // A held-low line must rise before another start edge is accepted
        if (rx_s) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_BREAK;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign pop      = out_valid && out_ready;
  assign full     = (level == DEPTH_L);
  assign push_ok  = push && (!full || pop);
  assign out_data = mem[rd_ptr];

  always_comb begin
    case ({push_ok, pop})
      2'b10:   level_n = level + LW'(1);
      2'b01:   level_n = level - LW'(1);
      default: level_n = level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      dbg_last  <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
        dbg_last    <= shreg;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level     <= level_n;
      out_valid <= (level_n != '0);
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor at 8 clocks per bit and a 4-deep FIFO.
module tb_uart_rx_monitor;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic out_ready = 1'b0;
  logic clr_overflow = 1'b0;
  logic [7:0] out_data;
  logic out_valid;
  logic [$clog2(DEPTH):0] level;
  logic framing_err;
  logic overflow;
  logic [7:0] dbg_last;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .framing_err(framing_err), .overflow(overflow),
    .clr_overflow(clr_overflow), .dbg_last(dbg_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  int cyc = 0;
  int rise_cyc = 0;
  int valid_hi_cnt = 0;
  int ferr_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: every accepted byte must be the oldest expected one
  always @(negedge clk) begin
    prev_valid <= out_valid;
    if (out_valid && !prev_valid) rise_cyc <= cyc;
    if (out_valid) valid_hi_cnt <= valid_hi_cnt + 1;
    if (framing_err) ferr_cnt <= ferr_cnt + 1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_byte", {24'd0, out_data}, 32'h100);
      else check("rx_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int c0, h0, f0;
    wait_clks(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_dbg", 32'(dbg_last), 32'h00);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(framing_err), 32'd0);
    rst = 1'b0;
    wait_clks(5);

    // single byte, consumer always ready
    out_ready = 1'b1;
    c0 = cyc;
    h0 = valid_hi_cnt;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_clks(10);
    check("t1_latency", 32'(rise_cyc - c0), 32'd79);
    check("t1_valid_cycles", 32'(valid_hi_cnt - h0), 32'd1);
    check("t1_level", 32'(level), 32'd0);
    check("t1_dbg", 32'(dbg_last), 32'h55);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // short low glitch is rejected at the start sample
    h0 = valid_hi_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(2);
    rx = 1'b1;
    wait_clks(20);
    check("t2_no_valid", 32'(valid_hi_cnt - h0), 32'd0);
    check("t2_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t2_level", 32'(level), 32'd0);

    // bad stop bit followed by a long break
    h0 = valid_hi_cnt;
    f0 = ferr_cnt;
    send_byte(8'hA3, 1'b0);
    wait_clks(20 * CPB);
    check("t3_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    check("t3_no_valid", 32'(valid_hi_cnt - h0), 32'd0);
    check("t3_level", 32'(level), 32'd0);
    rx = 1'b1;
    wait_clks(CPB);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    wait_clks(10);
    check("t3_dbg", 32'(dbg_last), 32'h3C);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // overflow: five back-to-back bytes into a stalled 4-deep FIFO
    out_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    wait_clks(4);
    check("t4_level", 32'(level), 32'd4);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_dbg", 32'(dbg_last), 32'h04);
    out_ready = 1'b1;
    wait_clks(8);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_level_empty", 32'(level), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    wait_clks(1);
    clr_overflow = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);

    // full FIFO with a pop on the same edge as the fifth push
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(8'h11 + 8'(b));
      send_byte(8'h11 + 8'(b), 1'b1);
    end
    exp_q.push_back(8'h15);
    fork
      send_byte(8'h15, 1'b1);
      begin
        wait_clks(78);
        out_ready = 1'b1;
        wait_clks(1);
        out_ready = 1'b0;
      end
    join
    wait_clks(3);
    check("t5_level", 32'(level), 32'd4);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_dbg", 32'(dbg_last), 32'h15);
    out_ready = 1'b1;
    wait_clks(8);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_level_empty", 32'(level), 32'd0);

    // reset mid-frame clears a buffered byte; only the following frame arrives
    out_ready = 1'b0;
    send_byte(8'h5A, 1'b1);
    wait_clks(3);
    check("t6_pre_level", 32'(level), 32'd1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        wait_clks(30);
        rst = 1'b1;
        wait_clks(2);
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_dbg", 32'(dbg_last), 32'h00);
        rst = 1'b0;
      end
    join
    wait_clks(10);
    out_ready = 1'b1;
    exp_q.push_back(8'hC9);
    send_byte(8'hC9, 1'b1);
    wait_clks(10);
    check("t6_dbg", 32'(dbg_last), 32'hC9);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check("t6_level", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
